fp_add_seq: RTL and testbench

Multi-cycle IEEE-754 floating-point adder that serves the `add_a`/`add_b`/`add_start` → `add_sum`/`add_ready` handshake. The angle-normalization and other trig pre-processing FSMs issue this request as initiators. It is the responder end of that interface. It accepts one operand pair per request, computes a fixed-latency, round-to-nearest-even sum, and pulses `add_ready` with the held result. An initiator may wire its add ports directly to this block.

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_lzc.sv | 25 ++
 rtl/fp_add_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fp_add_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential floating-point adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fp_pkg;

  localparam int EXP_BIAS = 127;

  // Canonical quiet NaN for the default binary32 format: {0, all-ones, 1, zeros}.
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    OP_ZERO,
    OP_FINITE,
    OP_INF,
    OP_NAN
  } op_cls_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND
  } add_state_t;

  // Denormals (exp == 0) are deliberately classed as zero.
  function automatic op_cls_t fp_classify(input logic exp_zero,
                                          input logic exp_ones,
                                          input logic man_nz);
    if (exp_zero)
      return OP_ZERO;
    else if (exp_ones)
      return man_nz ? OP_NAN : OP_INF;
    else
      return OP_FINITE;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter used by the adder's normalisation step.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of din.
//
// Ports:
//   din  in  WIDTH  : value to scan from the MSB down
//   cnt  out CNT_W  : number of leading zeros (WIDTH when din is all zero)
module fp_lzc #(
  parameter int WIDTH = 28,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i])
        cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 adder, round-to-nearest-even, denormals flushed to zero.
// Latency: start sampled at edge T0, add_sum/add_ready updated at edge T5.
// Backpressure: none; add_start is ignored while busy, never queued.
//
// Ports:
//   clk        in  1 : rising-edge clock
//   reset      in  1 : asynchronous active-low reset
//   add_start  in  1 : request strobe, sampled only in IDLE
//   add_a/b    in  W : operands {sign, exp, mantissa}
//   add_sum    out W : result, held until next result or reset
//   add_ready  out 1 : one-cycle pulse, add_sum valid
//   add_busy   out 1 : high from the accepting edge through the ready cycle
module fp_add_seq
  import fp_pkg::*;
#(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            add_start,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   add_a,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   add_b,
  output logic [EXP_LEN+MANTISSA_LEN:0]   add_sum,
  output logic                            add_ready,
  output logic                            add_busy
);

  localparam int W  = EXP_LEN + MANTISSA_LEN + 1;
  localparam int M  = MANTISSA_LEN;
  localparam int XW = M + 5;               // {carry, hidden, mantissa, G, R, S}
  localparam int CW = $clog2(XW + 1);
  localparam int EW = EXP_LEN + 1;         // one spare bit to see overflow

  localparam logic [W-1:0]       QNAN     = {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(M-1){1'b0}}};
  localparam logic [EXP_LEN-1:0] FAR      = EXP_LEN'(M + 3);
  localparam logic [EW-1:0]      EXP_ONES = {1'b0, {EXP_LEN{1'b1}}};

  add_state_t state_q, state_d;

  logic [W-1:0]       op_a_q, op_b_q;
  logic               r_sign, r_eff_sub, r_zero, r_spec;
  logic [W-1:0]       r_spec_res;
  logic [EXP_LEN-1:0] r_diff;
  logic [EW-1:0]      r_exp;
  logic [XW-1:0]      r_sig_l, r_sig_s;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (add_start) state_d = ST_UNPACK;
      ST_UNPACK: state_d = ST_ALIGN;
      ST_ALIGN:  state_d = ST_ADD;
      ST_ADD:    state_d = ST_NORM;
      ST_NORM:   state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign add_busy = (state_q != ST_IDLE) || add_ready;

  // ---------------- UNPACK ----------------
  logic               sa, sb;
  logic [EXP_LEN-1:0] ea, eb;
  logic [M-1:0]       ma, mb;
  logic [M:0]         sig_a, sig_b;
  logic [W-2:0]       mag_a, mag_b;
  logic               a_ge_b;
  op_cls_t            ca, cb;
  logic               spec_hit;
  logic [W-1:0]       spec_res;

  assign sa = op_a_q[W-1];
  assign sb = op_b_q[W-1];
  assign ea = op_a_q[W-2:M];
  assign eb = op_b_q[W-2:M];
  assign ma = op_a_q[M-1:0];
  assign mb = op_b_q[M-1:0];

  assign ca = fp_classify(ea == '0, &ea, |ma);
  assign cb = fp_classify(eb == '0, &eb, |mb);

  // Denormals become zero here, so they also compare as the smallest magnitude.
  assign sig_a  = (ea == '0) ? '0 : {1'b1, ma};
  assign sig_b  = (eb == '0) ? '0 : {1'b1, mb};
  assign mag_a  = (ea == '0) ? '0 : op_a_q[W-2:0];
  assign mag_b  = (eb == '0) ? '0 : op_b_q[W-2:0];
  assign a_ge_b = (mag_a >= mag_b);

  // Results that bypass the datapath; captured now, emitted in ROUND.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    if (ca == OP_NAN || cb == OP_NAN || (ca == OP_INF && cb == OP_INF && sa != sb))
      spec_res = QNAN;
    else if (ca == OP_INF)
      spec_res = op_a_q;
    else if (cb == OP_INF)
      spec_res = op_b_q;
    else if (ca == OP_ZERO && cb == OP_ZERO)
      spec_res = {sa & sb, {(W-1){1'b0}}};
    else if (ca == OP_ZERO)
      spec_res = op_b_q;
    else if (cb == OP_ZERO)
      spec_res = op_a_q;
    else
      spec_hit = 1'b0;
  end

  // ---------------- ALIGN ----------------
  logic [XW-1:0] sh_mask, sh_val, aligned;
  logic          sh_lost;

  assign sh_val  = r_sig_s >> r_diff;
  assign sh_mask = ~({XW{1'b1}} << r_diff);
  assign sh_lost = |(r_sig_s & sh_mask);

  always_comb begin
    if (r_diff >= FAR)
      aligned = {{(XW-1){1'b0}}, |r_sig_s};
    else
      aligned = sh_val | {{(XW-1){1'b0}}, sh_lost};
  end

  // ---------------- ADD ----------------
  // L >= S in magnitude, so the difference never goes negative.
  logic [XW-1:0] sum;
  assign sum = r_eff_sub ? (r_sig_l - r_sig_s) : (r_sig_l + r_sig_s);

  // ---------------- NORM ----------------
  logic [CW-1:0] lz, lsh;
  logic [XW-1:0] n_sig;
  logic [EW-1:0] n_exp;
  logic          n_zero, n_sign;

  fp_lzc #(.WIDTH(XW), .CNT_W(CW)) u_lzc (
    .din (r_sig_l),
    .cnt (lz)
  );

  // lz counts the carry slot too; the hidden bit sits one below it.
  assign lsh = lz - CW'(1);

  always_comb begin
    n_sig  = r_sig_l;
    n_exp  = r_exp;
    n_zero = 1'b0;
    n_sign = r_sign;
    if (r_sig_l[XW-1]) begin
      n_sig = {1'b0, r_sig_l[XW-1:2], r_sig_l[1] | r_sig_l[0]};
      n_exp = r_exp + EW'(1);
    end else if (r_sig_l == '0) begin
      n_zero = 1'b1;                 // exact cancellation is +0
      n_sign = 1'b0;
    end else if (r_exp <= EW'(lsh)) begin
      n_zero = 1'b1;                 // underflow flushes to signed zero
    end else begin
      n_sig = r_sig_l << lsh;
      n_exp = r_exp - EW'(lsh);
    end
  end

  // ---------------- ROUND ----------------
  logic          rnd_inc;
  logic [M+1:0]  rnd;
  logic [EW-1:0] exp_r;
  logic [M-1:0]  man_r;
  logic [W-1:0]  result;

  assign rnd_inc = r_sig_l[2] & (r_sig_l[1] | r_sig_l[0] | r_sig_l[3]);
  assign rnd     = {1'b0, r_sig_l[M+3:3]} + {{(M+1){1'b0}}, rnd_inc};

  always_comb begin
    if (rnd[M+1]) begin
      exp_r = r_exp + EW'(1);
      man_r = rnd[M:1];
    end else begin
      exp_r = r_exp;
      man_r = rnd[M-1:0];
    end
    if (r_spec)
      result = r_spec_res;
    else if (r_zero)
      result = {r_sign, {(W-1){1'b0}}};
    else if (exp_r >= EXP_ONES)
      result = {r_sign, {EXP_LEN{1'b1}}, {M{1'b0}}};
    else
      result = {r_sign, exp_r[EXP_LEN-1:0], man_r};
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      r_sign     <= 1'b0;
      r_eff_sub  <= 1'b0;
      r_zero     <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
      r_diff     <= '0;
      r_exp      <= '0;
      r_sig_l    <= '0;
      r_sig_s    <= '0;
      add_sum    <= '0;
      add_ready  <= 1'b0;
    end else begin
      add_ready <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (add_start) begin
            op_a_q <= add_a;
            op_b_q <= add_b;
          end
        end
        ST_UNPACK: begin
          r_eff_sub  <= sa ^ sb;
          r_spec     <= spec_hit;
          r_spec_res <= spec_res;
          if (a_ge_b) begin
            r_sign  <= sa;
            r_exp   <= {1'b0, ea};
            r_diff  <= ea - eb;
            r_sig_l <= {1'b0, sig_a, 3'b000};
            r_sig_s <= {1'b0, sig_b, 3'b000};
          end else begin
            r_sign  <= sb;
            r_exp   <= {1'b0, eb};
            r_diff  <= eb - ea;
            r_sig_l <= {1'b0, sig_b, 3'b000};
            r_sig_s <= {1'b0, sig_a, 3'b000};
          end
        end
        ST_ALIGN: r_sig_s <= aligned;
        ST_ADD:   r_sig_l <= sum;
        ST_NORM: begin
          r_sig_l <= n_sig;
          r_exp   <= n_exp;
          r_zero  <= n_zero;
          r_sign  <= n_sign;
        end
        ST_ROUND: begin
          add_sum   <= result;
          add_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: scoreboard of expected sums and
// expected ready cycles, checked whenever add_ready is seen.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        add_start = 1'b0;
  logic [31:0] add_a = '0;
  logic [31:0] add_b = '0;
  logic [31:0] add_sum;
  logic        add_ready;
  logic        add_busy;

  fp_add_seq #(.EXP_LEN(8), .MANTISSA_LEN(23)) dut (
    .clk       (clk),
    .reset     (reset),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_ready (add_ready),
    .add_busy  (add_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  int          when_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    end
  endtask

  // Called at a negedge; the following posedge is T0, ready expected after T5.
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] want, input bit track);
    add_a     = a;
    add_b     = b;
    add_start = 1'b1;
    if (track) begin
      exp_q.push_back(want);
      when_q.push_back(cyc + 6);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    @(negedge clk);
    drive_start(a, b, want, 1'b1);
    @(negedge clk);
    add_start = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Scoreboard consumer.
  initial begin
    logic [31:0] w;
    int          t;
    forever begin
      @(negedge clk);
      if (add_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_ready", 32'(add_ready), 32'd0);
        end else begin
          w = exp_q.pop_front();
          t = when_q.pop_front();
          check("sum", add_sum, w);
          check("ready_cycle", cyc, t);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sum",   add_sum,          32'h0);
    check("rst_ready", 32'(add_ready),   32'h0);
    check("rst_busy",  32'(add_busy),    32'h0);
    reset = 1'b1;
    @(negedge clk);

    // 1.0 + 2.0 with busy trace across the whole operation.
    @(negedge clk);
    drive_start(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) add_start = 1'b0;
      check($sformatf("busy_after_T%0d", k - 1), 32'(add_busy), (k <= 6) ? 32'd1 : 32'd0);
    end

    run_op(32'h4049_0FDB, 32'hC049_0FDB, 32'h0000_0000);   // pi - pi
    run_op(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);   // tie to even
    run_op(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);   // tie, odd lsb
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);   // overflow
    run_op(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);   // inf - inf
    run_op(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000);   // NaN
    run_op(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);   // -inf + finite
    run_op(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);   // -0 + -0
    run_op(32'h0000_0000, 32'h8000_0000, 32'h0000_0000);   // +0 + -0
    run_op(32'h3F80_0000, 32'h0040_0000, 32'h3F80_0000);   // denormal flushed

    // Re-pulsed start mid-operation is ignored; start at T6 is accepted.
    @(negedge clk);
    drive_start(32'h40E0_0000, 32'hC000_0000, 32'h40A0_0000, 1'b1);
    @(negedge clk);
    add_start = 1'b0;
    @(negedge clk);
    drive_start(32'h3F80_0000, 32'hC000_0000, 32'h0, 1'b0);  // sampled at T2
    @(negedge clk);
    add_start = 1'b0;
    add_a     = 32'h1234_5678;
    repeat (3) @(negedge clk);
    drive_start(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);  // sampled at T6
    @(negedge clk);
    add_start = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of an operation: outputs clear, no ready pulse.
    @(negedge clk);
    drive_start(32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b0);
    @(negedge clk);
    add_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_sum",   add_sum,        32'h0);
    check("midrst_ready", 32'(add_ready), 32'h0);
    check("midrst_busy",  32'(add_busy),  32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(32'h3F80_0000, 32'hBF00_0000, 32'h3F00_0000);   // 1.0 - 0.5

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
